data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data load/store port; it services the requests raised by the decoder's data_read/data_write controls.
- Byte-addressed, little-endian internal RAM with a programmable fixed access latency.
- Valid/ready request channel in, valid/ready response channel out. One outstanding request at a time.
- Performs RV32I load/store sizing and extension from funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).

Parameters:
- ADDR_WIDTH, 16, byte-address width; RAM holds 2**ADDR_WIDTH bytes.
- LATENCY, 2, cycles from request acceptance to rsp_valid_o assertion; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-low
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_write_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RV32I load/store funct3
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  32  store data, low bits used for SB/SH
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  core accepts response
- rsp_rdata_o  output  32  load result, already extended; 0 for stores and errors
- rsp_err_o  output  1  request was illegal; no side effects
- busy_o  output  1  request in flight (WAIT or RESP)

Behaviour:
- Reset (rst_i low at a clock edge):
  - state=IDLE; counter=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0 while rst_i is low.
  - RAM contents are not reset.
- FSM IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch write, funct3, addr and wdata; load counter=LATENCY-1; go to WAIT.
- FSM WAIT:
  - req_ready_o=0; decrement counter each cycle.
  - On the cycle counter==0, perform the access:
    - store: commit byte enables to RAM at that edge;
    - load: capture extended data into rsp_rdata_o.
  - Then go to RESP.
- FSM RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable.
  - On rsp_ready_i: go to IDLE and clear rsp_valid_o.
  - No new request is accepted in the same cycle.
- Latency: request accepted at edge N gives rsp_valid_o high after edge N+LATENCY. Minimum round trip per request is LATENCY+1 cycles.
- Load extension:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111: err=1, rdata=0.
- Store width:
  - 000 SB: byte [addr] <= wdata[7:0].
  - 001 SH: wdata[15:0] to addr, addr+1.
  - 010 SW: all four bytes.
  - Any other funct3: err=1, no write.
- Little-endian ordering: byte at addr is bits [7:0] of the word.
- Illegal requests still take LATENCY cycles and produce a response with err=1.
- Reset mid-operation:
  - A request in WAIT before its commit edge is dropped and the store is not written.
  - A response pending in RESP is discarded.
- rsp_ready_i outside RESP is ignored. req_valid_i outside IDLE is ignored; the input fields need not be held.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]!=0, or a word access with addr[1:0]!=0, returns err=1, rdata=0 and no write.
- Undefined:
  - Low address bits are forced to natural alignment: halfword clears addr[0], word clears addr[1:0].
  - The access proceeds normally with err=0.
  - No access ever wraps past the top of RAM.

Test Plan:
- SW addr 0x0010 data 0x8899AABB, then LW 0x0010 -> rdata 0x8899AABB. rsp_valid_o rises LATENCY cycles after each accept; err=0.
- After the SW above:
  - LB 0x0013 -> 0xFFFFFF88.
  - LBU 0x0013 -> 0x00000088.
  - LH 0x0012 -> 0xFFFF8899.
  - LHU 0x0010 -> 0x0000AABB.
- SB 0x0011 data 0x123455CC, then LW 0x0010 -> 0x8899CCBB. Only byte 1 changes.
- Response backpressure: rsp_ready_i held 0 for 5 cycles.
  - rsp_valid_o stays 1 and rdata stays stable.
  - req_ready_o stays 0 and a second request is not accepted until the response handshake completes.
- Illegal and misaligned requests:
  - funct3=011 store to 0x0020 -> err=1; a subsequent LW 0x0020 is unchanged.
  - LW 0x0012 with DATA_MEM_MISALIGN_TRAP_EN -> err=1, rdata=0.
  - LW 0x0012 without it -> data of 0x0010, err=0.
- rst_i low during WAIT of SW 0x0030 data 0xDEADBEEF (LATENCY=3, reset before commit):
  - Outputs read 0 during reset.
  - After release, req_ready_o=1 and LW 0x0030 returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-port memory responder: byte-addressed little-endian RAM behind a valid/ready
// request/response pair with fixed LATENCY. Optional misalignment trap: DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [7:0]            mem [DEPTH];

  logic [ADDR_WIDTH-3:0] word_addr;
  logic [1:0]            lane;
  logic                  legal_op;
  logic                  misaligned;
  logic                  acc_err;
  logic [31:0]           rd_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_data;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic                  commit_store;

  assign word_addr = addr_q[ADDR_WIDTH-1:2];
  assign lane      = addr_q[1:0];

  // Request legality and alignment, decoded from the latched request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal_op   = 1'b0;
    misaligned = 1'b0;
    if (wr_q) begin
      legal_op = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    end else begin
      legal_op = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                 (f3_q == 3'b100) || (f3_q == 3'b101);
    end
    if (f3_q[1:0] == 2'b01) begin
      misaligned = lane[0];
    end else if (f3_q[1:0] == 2'b10) begin
      misaligned = (lane != 2'b00);
    end
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    acc_err = !legal_op || misaligned;
`else
    acc_err = !legal_op;
`endif
  end

  // Word containing the access; halfword/word lanes are forced to natural alignment,
  // so an access never straddles a word and never wraps past the top of RAM.
  assign rd_word = {mem[{word_addr, 2'd3}], mem[{word_addr, 2'd2}],
                    mem[{word_addr, 2'd1}], mem[{word_addr, 2'd0}]};

  always_comb begin
    byte_sel  = 8'(rd_word >> {lane, 3'b000});
    half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
      default: begin
        be    = 4'b0000;
        wlane = wdata_q;
      end
    endcase
  end

  // A reset landing on the commit edge suppresses the write.
  assign commit_store = rst_i && (state == S_WAIT) && (cnt == 4'd0) && wr_q && !acc_err;

  // NOTE: the RAM array has no reset; its contents survive rst_i by design.
  always_ff @(posedge clk_i) begin
    if (commit_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[{word_addr, 2'(i)}] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          if (req_valid_i && req_ready_o) begin
            wr_q        <= req_write_i;
            f3_q        <= req_funct3_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            cnt         <= CNT_INIT;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= acc_err;
            rsp_rdata_o <= (acc_err || wr_q) ? 32'd0 : load_data;
            state       <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          req_ready_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
